// File: rtl/ibex_efpga_issue.sv
// Issue/response sequencer for single custom (CX) instructions dispatched to an eFPGA unit.
// Holds one op and one result; handles flush, timeout and writeback backpressure.
module ibex_efpga_issue #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid_i,
  output logic        id_ready_o,
  input  logic [1:0]  id_operator_i,
  input  logic [31:0] id_operand_a_i,
  input  logic [31:0] id_operand_b_i,
  input  logic [3:0]  id_delay_i,
  input  logic        flush_i,
  output logic        efpga_en_o,
  output logic [1:0]  efpga_operator_o,
  output logic [31:0] efpga_operand_a_o,
  output logic [31:0] efpga_operand_b_o,
  output logic [3:0]  efpga_delay_o,
  input  logic        efpga_ready_i,
  input  logic [31:0] efpga_result_i,
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic [31:0] wb_result_o,
  output logic        wb_error_o,
  output logic        busy_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StDrain} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]      op_q;
  logic [31:0]     a_q, b_q;
  logic [3:0]      delay_q;
  logic [31:0]     res_q, res_d;
  logic            err_q, err_d;
  logic            accept;
  logic            timeout;

  assign id_ready_o = (state_q == StIdle) && !flush_i;
  assign accept     = id_valid_i && id_ready_o;
  assign busy_o     = (state_q != StIdle);

  // Saturating so a long DRAIN can never wrap back below the timeout threshold.
  assign cnt_inc = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + CntW'(1);
  assign timeout = (cnt_q >= CntW'(TIMEOUT - 1));

  assign efpga_operator_o  = op_q;
  assign efpga_operand_a_o = a_q;
  assign efpga_operand_b_o = b_q;
  assign efpga_delay_o     = delay_q;
  assign wb_result_o       = res_q;
  assign wb_error_o        = err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    err_d      = err_q;
    efpga_en_o = 1'b0;
    wb_valid_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StIssue;
      end
      StIssue: begin
        cnt_d      = '0;
        efpga_en_o = !flush_i;
        state_d    = flush_i ? StIdle : StWait;
      end
      StWait: begin
        cnt_d = cnt_inc;
        // A response always beats a same-cycle timeout; a flush discards it.
        if (efpga_ready_i) begin
          if (flush_i) begin
            state_d = StIdle;
          end else begin
            res_d   = efpga_result_i;
            err_d   = 1'b0;
            state_d = StResp;
          end
        end else if (flush_i) begin
          state_d = StDrain;
        end else if (timeout) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        wb_valid_o = 1'b1;
        if (flush_i || wb_ready_i) state_d = StIdle;
      end
      StDrain: begin
        cnt_d = cnt_inc;
        if (efpga_ready_i || timeout) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Op fields only change on acceptance, so they stay stable for the whole op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      delay_q <= '0;
    end else if (accept) begin
      op_q    <= id_operator_i;
      a_q     <= id_operand_a_i;
      b_q     <= id_operand_b_i;
      delay_q <= id_delay_i;
    end
  end

endmodule

// File: doc/ibex_efpga_issue.md
IBEX_EFPGA_ISSUE -- requirements
Module: ibex_efpga_issue

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum WAIT-state cycles before an issued operation is abandoned; legal range 2..255.
REQ-002 clk  input  1  core clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 id_valid_i  input  1  ID stage presents a custom (CX) instruction.
REQ-005 id_ready_o  output  1  block accepts the instruction this cycle.
REQ-006 id_operator_i  input  2  custom-op selector.
REQ-007 id_operand_a_i / id_operand_b_i  input  32 each  source operands.
REQ-008 id_delay_i  input  4  per-op eFPGA processing delay.
REQ-009 flush_i  input  1  pipeline kill of the in-flight custom op.
REQ-010 efpga_en_o  output  1  one-cycle start pulse to eFPGA unit.
REQ-011 efpga_operator_o 2, efpga_operand_a_o 32, efpga_operand_b_o 32, efpga_delay_o 4  outputs  latched op fields.
REQ-012 efpga_ready_i  input  1  eFPGA done; single-cycle pulse.
REQ-013 efpga_result_i  input  32  eFPGA result, valid while efpga_ready_i high.
REQ-014 wb_valid_o  output  1  result available to writeback.
REQ-015 wb_ready_i  input  1  writeback consumes result.
REQ-016 wb_result_o  output  32  captured result.
REQ-017 wb_error_o  output  1  op timed out; wb_result_o is 0.
REQ-018 busy_o  output  1  state != IDLE.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, RESP, DRAIN.
REQ-020 id_ready_o = (state==IDLE) && !flush_i; handshake id_valid_i&&id_ready_o latches operator, operands, delay; next state ISSUE.
REQ-021 ISSUE: efpga_en_o = !flush_i for exactly this one cycle; timeout counter cleared; next WAIT, or IDLE if flush_i.
REQ-022 efpga_* op outputs SHALL be driven from latched registers, stable from ISSUE until return to IDLE.
REQ-023 WAIT: counter increments each cycle (width clog2(TIMEOUT)+1, no wrap); efpga_ready_i high -> capture efpga_result_i, error=0, next RESP.
REQ-024 WAIT: counter==TIMEOUT-1 and efpga_ready_i low -> result=0, error=1, next RESP; ready and timeout in same cycle -> ready wins.
REQ-025 efpga_ready_i in IDLE, ISSUE, RESP SHALL be ignored.
REQ-026 RESP: wb_valid_o=1; wb_result_o/wb_error_o held stable until wb_valid_o&&wb_ready_i, then IDLE; no new acceptance in that cycle.
REQ-027 flush_i in WAIT (no same-cycle efpga_ready_i) -> DRAIN; DRAIN waits for efpga_ready_i or timeout (counter continues), discards result, next IDLE, wb_valid_o never asserted.
REQ-028 flush_i in WAIT with efpga_ready_i same cycle -> result discarded, next IDLE.
REQ-029 flush_i in RESP -> pending result dropped, next IDLE; flush_i in IDLE has no state effect.
REQ-030 Latency: acceptance cycle 0 with eFPGA delay d -> efpga_en_o cycle 1, wb_valid_o first high cycle d+4.
REQ-031 Only one op in flight; no buffering beyond the single latched op and single result register.

Reset
REQ-032 rst_n low at a rising edge -> state IDLE, counter 0, all latched registers 0; next cycle id_ready_o=1, all other outputs 0.
REQ-033 Reset mid-operation (any state) SHALL abandon the op with no wb_valid_o pulse; eFPGA unit shares rst_n.

Verification
REQ-034 Op 0, a=0xDEADBEEF, delay 2, wb_ready_i=1 -> efpga_en_o high cycle 1 only, wb_valid_o cycle 6, wb_result_o=0xDEADBEEF, wb_error_o=0.
REQ-035 Backpressure: wb_ready_i low 5 cycles in RESP -> wb_valid_o, wb_result_o stable throughout, id_ready_o=0; release -> IDLE next cycle.
REQ-036 TIMEOUT=8, eFPGA never responds -> wb_valid_o 9 cycles after ISSUE (cycle 10), wb_error_o=1, wb_result_o=0.
REQ-037 flush_i in cycle 3 of delay-5 op -> no wb_valid_o, busy_o until cycle after eFPGA ready pulse, then new op accepted and completes normally.
REQ-038 flush_i in ISSUE -> efpga_en_o stays 0, IDLE next cycle; rst_n low mid-WAIT -> IDLE, outputs 0, no wb_valid_o.
